// File: rtl/sdram_rd_ctrl_burst.sv
// SDRAM read-path controller: ACTIVE, READ, capture after CAS latency, optional BST,
// PRECHARGE all, then an end pulse back to the arbiter. All outputs registered.
module sdram_rd_ctrl_burst #(
  parameter int DATA_W  = 16,
  parameter int BA_W    = 2,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 9,
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  parameter int BURST_W = COL_W + 1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        init_end_i,
  input  logic                        rd_en_i,
  input  logic [BA_W+ROW_W+COL_W-1:0] rd_addr_i,
  input  logic [BURST_W-1:0]          rd_burst_len_i,
  input  logic [DATA_W-1:0]           rd_data_i,
  output logic                        rd_ack_o,
  output logic                        rd_end_o,
  output logic                        rd_busy_o,
  output logic [3:0]                  rd_cmd_o,
  output logic [BA_W-1:0]             rd_ba_o,
  output logic [ROW_W-1:0]            rd_addr_o,
  output logic [DATA_W-1:0]           rd_sdram_data_o,
  output logic                        rd_data_valid_o
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam int         CNT_W   = BURST_W + 2;
  localparam logic [BURST_W-1:0] FULL_PAGE = BURST_W'(1) << COL_W;

  typedef enum logic [2:0] {S_IDLE, S_ACT, S_TRCD, S_RD, S_DATA, S_PRE, S_TRP} state_t;

  state_t              r_state;
  logic [BURST_W-1:0]  r_cnt;
  logic [BURST_W-1:0]  r_len;
  logic [BA_W-1:0]     r_bank;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [3:0]          r_cmd;
  logic [BA_W-1:0]     r_ba;
  logic [ROW_W-1:0]    r_addr;
  logic                r_ack;
  logic                r_end;
  logic                r_busy;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;

  logic [CNT_W-1:0]    w_k1;
  logic [CNT_W-1:0]    w_len;
  logic                w_ack_nxt;
  logic                w_bst_nxt;
  logic                w_data_done;
  logic [ROW_W-1:0]    w_col_addr;
  logic [ROW_W-1:0]    w_pre_addr;

  // r_cnt in DATA holds k for cycle READ+k; decisions are made for cycle READ+k+1
  assign w_k1        = {2'b00, r_cnt} + CNT_W'(1);
  assign w_len       = {2'b00, r_len};
  assign w_ack_nxt   = (w_k1 >= CNT_W'(CAS_LAT)) && (w_k1 <= CNT_W'(CAS_LAT) + w_len - CNT_W'(1));
  assign w_bst_nxt   = (w_k1 == w_len) && (r_len != FULL_PAGE);
  assign w_data_done = (w_k1 == CNT_W'(CAS_LAT) + w_len);

  always_comb begin
    w_col_addr              = '0;
    w_col_addr[COL_W-1:0]   = r_col;
    w_col_addr[10]          = 1'b0;
    w_pre_addr              = '0;
    w_pre_addr[10]          = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_cmd   <= CMD_NOP;
      r_ba    <= '0;
      r_addr  <= '0;
      r_ack   <= 1'b0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cmd  <= CMD_NOP;
      r_ack  <= 1'b0;
      r_end  <= 1'b0;
      r_busy <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (rd_en_i && init_end_i && (rd_burst_len_i != '0)) begin
            {r_bank, r_row, r_col} <= rd_addr_i;
            r_len   <= rd_burst_len_i;
            r_state <= S_ACT;
            r_cmd   <= CMD_ACT;
            r_ba    <= rd_addr_i[BA_W+ROW_W+COL_W-1 -: BA_W];
            r_addr  <= rd_addr_i[ROW_W+COL_W-1 -: ROW_W];
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ACT: begin
          if (T_RCD == 1) begin
            r_state <= S_RD;
            r_cmd   <= CMD_RD;
            r_addr  <= w_col_addr;
          end else begin
            r_state <= S_TRCD;
            r_cnt   <= BURST_W'(1);
          end
        end
        S_TRCD: begin
          if (r_cnt == BURST_W'(T_RCD - 1)) begin
            r_state <= S_RD;
            r_cmd   <= CMD_RD;
            r_addr  <= w_col_addr;
          end else begin
            r_cnt <= r_cnt + BURST_W'(1);
          end
        end
        S_RD: begin
          r_state <= S_DATA;
          r_cnt   <= BURST_W'(1);
          if (r_len == BURST_W'(1)) r_cmd <= CMD_BST;
        end
        S_DATA: begin
          if (w_data_done) begin
            r_state <= S_PRE;
            r_cmd   <= CMD_PRE;
            r_addr  <= w_pre_addr;
          end else begin
            r_cnt <= r_cnt + BURST_W'(1);
            r_ack <= w_ack_nxt;
            if (w_bst_nxt) r_cmd <= CMD_BST;
          end
        end
        S_PRE: begin
          r_state <= S_TRP;
          r_cnt   <= BURST_W'(1);
          r_end   <= (T_RP == 1);
        end
        S_TRP: begin
          if (r_cnt == BURST_W'(T_RP)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + BURST_W'(1);
            r_end <= ((r_cnt + BURST_W'(1)) == BURST_W'(T_RP));
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Capture stage: the word present while ack is high is registered for the next cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_ack;
      if (r_ack) r_data <= rd_data_i;
    end
  end

  assign rd_ack_o        = r_ack;
  assign rd_end_o        = r_end;
  assign rd_busy_o       = r_busy;
  assign rd_cmd_o        = r_cmd;
  assign rd_ba_o         = r_ba;
  assign rd_addr_o       = r_addr;
  assign rd_sdram_data_o = r_data;
  assign rd_data_valid_o = r_valid;

endmodule

// File: tb/tb_sdram_rd_ctrl_burst.sv
// Directed bench for sdram_rd_ctrl_burst: default instance (CAS 3) and a CAS 2 instance
// share stimulus; per-cycle outputs are recorded and compared to hand-derived cycles.
module tb_sdram_rd_ctrl_burst;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;
  localparam int NMAX = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end;
  logic        rd_en;
  logic [23:0] addr;
  logic [9:0]  len;
  logic [15:0] dq;

  logic        ack [2];
  logic        fin [2];
  logic        busy[2];
  logic [3:0]  cmd [2];
  logic [1:0]  ba  [2];
  logic [12:0] ao  [2];
  logic [15:0] dout[2];
  logic        vld [2];

  logic [3:0]  t_cmd [2][NMAX];
  logic [12:0] t_addr[2][NMAX];
  logic [1:0]  t_ba  [2][NMAX];
  logic [15:0] t_data[2][NMAX];
  logic        t_bit [2][4][NMAX];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_rd_ctrl_burst u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_end_i(init_end), .rd_en_i(rd_en),
    .rd_addr_i(addr), .rd_burst_len_i(len), .rd_data_i(dq),
    .rd_ack_o(ack[0]), .rd_end_o(fin[0]), .rd_busy_o(busy[0]), .rd_cmd_o(cmd[0]),
    .rd_ba_o(ba[0]), .rd_addr_o(ao[0]), .rd_sdram_data_o(dout[0]), .rd_data_valid_o(vld[0])
  );

  sdram_rd_ctrl_burst #(.CAS_LAT(2)) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_end_i(init_end), .rd_en_i(rd_en),
    .rd_addr_i(addr), .rd_burst_len_i(len), .rd_data_i(dq),
    .rd_ack_o(ack[1]), .rd_end_o(fin[1]), .rd_busy_o(busy[1]), .rd_cmd_o(cmd[1]),
    .rd_ba_o(ba[1]), .rd_addr_o(ao[1]), .rd_sdram_data_o(dout[1]), .rd_data_valid_o(vld[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: drop rd_en after accept; 1: hold through cycle 13; 2: pulse on odd cycles 3..9
  task automatic capture(input int n, input int mode);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (mode == 0) rd_en = 1'b0;
      else if (mode == 1 && c >= 14) rd_en = 1'b0;
      else if (mode == 2) rd_en = (c >= 3 && c <= 9 && (c % 2) == 1);
      dq = 16'hA000 + 16'(c);
      for (int d = 0; d < 2; d++) begin
        t_cmd[d][c]  = cmd[d];
        t_addr[d][c] = ao[d];
        t_ba[d][c]   = ba[d];
        t_data[d][c] = dout[d];
        t_bit[d][0][c] = ack[d];
        t_bit[d][1][c] = vld[d];
        t_bit[d][2][c] = fin[d];
        t_bit[d][3][c] = busy[d];
      end
    end
  endtask

  task automatic start(input logic [23:0] a, input logic [9:0] l);
    @(posedge clk);
    #1;
    addr  = a;
    len   = l;
    rd_en = 1'b1;
  endtask

  function automatic int first_cmd(input int d, input logic [3:0] v, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) if (t_cmd[d][c] === v) return c;
    return -1;
  endfunction

  function automatic int cnt_cmd(input int d, input logic [3:0] v, input int lo, input int hi);
    int k = 0;
    for (int c = lo; c <= hi; c++) if (t_cmd[d][c] === v) k++;
    return k;
  endfunction

  function automatic int cnt_not_nop(input int d, input int lo, input int hi);
    int k = 0;
    for (int c = lo; c <= hi; c++) if (t_cmd[d][c] !== NOP) k++;
    return k;
  endfunction

  function automatic int first_bit(input int d, input int s, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) if (t_bit[d][s][c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int last_bit(input int d, input int s, input int lo, input int hi);
    for (int c = hi; c >= lo; c--) if (t_bit[d][s][c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int cnt_bit(input int d, input int s, input int lo, input int hi);
    int k = 0;
    for (int c = lo; c <= hi; c++) if (t_bit[d][s][c] === 1'b1) k++;
    return k;
  endfunction

  initial begin
    rst_n    = 1'b0;
    init_end = 1'b1;
    rd_en    = 1'b0;
    addr     = '0;
    len      = '0;
    dq       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd",   32'(cmd[0]),  32'(NOP));
    chk("rst_busy",  32'(busy[0]), 0);
    chk("rst_ack",   32'(ack[0]),  0);
    chk("rst_end",   32'(fin[0]),  0);
    chk("rst_valid", 32'(vld[0]),  0);
    chk("rst_ba",    32'(ba[0]),   0);
    chk("rst_addr",  32'(ao[0]),   0);
    chk("rst_data",  32'(dout[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // L=4 with default timing
    start({2'b01, 13'h0123, 9'h010}, 10'd4);
    capture(16, 0);
    chk("l4_act_cmd",   32'(t_cmd[0][1]), 32'(ACT));
    chk("l4_act_ba",    32'(t_ba[0][1]), 1);
    chk("l4_act_row",   32'(t_addr[0][1]), 32'h0123);
    chk("l4_c2_nop",    32'(t_cmd[0][2]), 32'(NOP));
    chk("l4_read_cyc",  first_cmd(0, RD, 1, 16), 3);
    chk("l4_read_col",  32'(t_addr[0][3]), 32'h0010);
    chk("l4_read_ba",   32'(t_ba[0][3]), 1);
    chk("l4_bst_cyc",   first_cmd(0, BST, 1, 16), 7);
    chk("l4_bst_cnt",   cnt_cmd(0, BST, 1, 16), 1);
    chk("l4_ack_first", first_bit(0, 0, 1, 16), 6);
    chk("l4_ack_last",  last_bit(0, 0, 1, 16), 9);
    chk("l4_ack_cnt",   cnt_bit(0, 0, 1, 16), 4);
    chk("l4_vld_first", first_bit(0, 1, 1, 16), 7);
    chk("l4_vld_cnt",   cnt_bit(0, 1, 1, 16), 4);
    chk("l4_data_c7",   32'(t_data[0][7]), 32'hA006);
    chk("l4_data_c10",  32'(t_data[0][10]), 32'hA009);
    chk("l4_pre_cyc",   first_cmd(0, PRE, 1, 16), 10);
    chk("l4_pre_addr",  32'(t_addr[0][10]), 32'h0400);
    chk("l4_end_cyc",   first_bit(0, 2, 1, 16), 12);
    chk("l4_end_cnt",   cnt_bit(0, 2, 1, 16), 1);
    chk("l4_busy_first", first_bit(0, 3, 1, 16), 1);
    chk("l4_busy_last", last_bit(0, 3, 1, 16), 12);
    chk("l4_busy_cnt",  cnt_bit(0, 3, 1, 16), 12);

    // rd_en pulses while busy must not start anything new
    start({2'b10, 13'h0042, 9'h005}, 10'd4);
    capture(20, 2);
    chk("pulse_act_cnt", cnt_cmd(0, ACT, 1, 20), 1);
    chk("pulse_pre_cnt", cnt_cmd(0, PRE, 1, 20), 1);
    chk("pulse_end_cnt", cnt_bit(0, 2, 1, 20), 1);
    chk("pulse_ba",      32'(t_ba[0][1]), 2);

    // L=1
    start({2'b00, 13'h0001, 9'h1FF}, 10'd1);
    capture(12, 0);
    chk("l1_read_cyc", first_cmd(0, RD, 1, 12), 3);
    chk("l1_read_col", 32'(t_addr[0][3]), 32'h01FF);
    chk("l1_bst_cyc",  first_cmd(0, BST, 1, 12), 4);
    chk("l1_ack_cyc",  first_bit(0, 0, 1, 12), 6);
    chk("l1_ack_cnt",  cnt_bit(0, 0, 1, 12), 1);
    chk("l1_pre_cyc",  first_cmd(0, PRE, 1, 12), 7);
    chk("l1_end_cyc",  first_bit(0, 2, 1, 12), 9);

    // full page on the CAS 2 instance
    start({2'b11, 13'h1FFF, 9'h000}, 10'd512);
    capture(525, 0);
    chk("fp_read_cyc",  first_cmd(1, RD, 1, 525), 3);
    chk("fp_no_bst",    cnt_cmd(1, BST, 1, 525), 0);
    chk("fp_ack_first", first_bit(1, 0, 1, 525), 5);
    chk("fp_ack_last",  last_bit(1, 0, 1, 525), 516);
    chk("fp_ack_cnt",   cnt_bit(1, 0, 1, 525), 512);
    chk("fp_pre_cyc",   first_cmd(1, PRE, 1, 525), 517);
    chk("fp_end_cyc",   first_bit(1, 2, 1, 525), 519);

    // request while init not done
    init_end = 1'b0;
    start({2'b01, 13'h0123, 9'h010}, 10'd4);
    capture(10, 1);
    rd_en    = 1'b0;
    init_end = 1'b1;
    chk("noinit_cmds", cnt_not_nop(0, 1, 10), 0);
    chk("noinit_busy", cnt_bit(0, 3, 1, 10), 0);
    chk("noinit_end",  cnt_bit(0, 2, 1, 10), 0);

    // zero-length request
    start({2'b01, 13'h0123, 9'h010}, 10'd0);
    capture(10, 1);
    rd_en = 1'b0;
    chk("zero_cmds", cnt_not_nop(0, 1, 10), 0);
    chk("zero_busy", cnt_bit(0, 3, 1, 10), 0);
    chk("zero_end",  cnt_bit(0, 2, 1, 10), 0);

    // held rd_en: back-to-back transactions
    start({2'b01, 13'h0123, 9'h010}, 10'd4);
    capture(30, 1);
    chk("b2b_act1",    first_cmd(0, ACT, 1, 1), 1);
    chk("b2b_act2",    first_cmd(0, ACT, 2, 30), 14);
    chk("b2b_idle13",  32'(t_bit[0][3][13]), 0);
    chk("b2b_act_cnt", cnt_cmd(0, ACT, 1, 30), 2);
    chk("b2b_end_cnt", cnt_bit(0, 2, 1, 30), 2);

    // asynchronous reset in cycle 8, then a clean restart
    start({2'b01, 13'h0123, 9'h010}, 10'd4);
    capture(8, 0);
    chk("rstmid_ack_before", 32'(ack[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cmd",   32'(cmd[0]),  32'(NOP));
    chk("rstmid_ack",   32'(ack[0]),  0);
    chk("rstmid_busy",  32'(busy[0]), 0);
    chk("rstmid_valid", 32'(vld[0]),  0);
    chk("rstmid_addr",  32'(ao[0]),   0);
    #2;
    rst_n = 1'b1;
    start({2'b10, 13'h0456, 9'h020}, 10'd2);
    capture(14, 0);
    chk("restart_act",  32'(t_cmd[0][1]), 32'(ACT));
    chk("restart_row",  32'(t_addr[0][1]), 32'h0456);
    chk("restart_read", first_cmd(0, RD, 1, 14), 3);
    chk("restart_col",  32'(t_addr[0][3]), 32'h0020);
    chk("restart_end",  first_bit(0, 2, 1, 14), 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
